// File: rtl/aes_round_sequencer_if.sv
// Handshake/status bundle between the AES round sequencer and its datapath/key unit.
interface aes_round_sequencer_if #(
    parameter int unsigned SUB_W = 5
);
    logic             start;
    logic             enc_dec;
    logic [1:0]       mode;
    logic             stall;
    logic             busy;
    logic             enc_dec_reg;
    logic [1:0]       mode_reg;
    logic [3:0]       round;
    logic [SUB_W-1:0] sub_round;
    logic             round_start;
    logic             round_complete;
    logic             key_gen;
    logic [3:0]       key_gen_round;
    logic             done;
    logic             err;

    // Requester side: issues operations and backpressure.
    modport master (
        output start, enc_dec, mode, stall,
        input  busy, enc_dec_reg, mode_reg, round, sub_round,
               round_start, round_complete, key_gen, key_gen_round, done, err
    );

    // Sequencer side.
    modport slave (
        input  start, enc_dec, mode, stall,
        output busy, enc_dec_reg, mode_reg, round, sub_round,
               round_start, round_complete, key_gen, key_gen_round, done, err
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Counter-based round controller for the iterative AES-128/192/256 core.
// Sequences the reverse key-schedule pass (decrypt only), round 0, and rounds 1..Nr.
// Optional feature macro: AES_SEQ_STALL_EN (stall input honoured when defined).
module aes_round_sequencer #(
    parameter int unsigned SUB_ROUNDS_ENC = 16,
    parameter int unsigned SUB_ROUNDS_DEC = 20,
    parameter int unsigned SUB_W          = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    aes_round_sequencer_if.slave  bus
);

    localparam logic [SUB_W-1:0] ENC_LAST = SUB_W'(SUB_ROUNDS_ENC - 1);
    localparam logic [SUB_W-1:0] DEC_LAST = SUB_W'(SUB_ROUNDS_DEC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYGEN = 3'd1,
        S_INIT   = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    logic [3:0]       r_round;
    logic [SUB_W-1:0] r_sub;
    logic [3:0]       r_kgr;
    logic [1:0]       r_mode;
    logic             r_enc_dec;
    logic             r_busy;
    logic             r_key_gen;

    state_t           w_next_state;
    logic [3:0]       w_round_nxt;
    logic [SUB_W-1:0] w_sub_nxt;
    logic [3:0]       w_kgr_nxt;
    logic [1:0]       w_mode_nxt;
    logic             w_enc_dec_nxt;
    logic             w_round_start;
    logic             w_round_complete;
    logic             w_done;
    logic             w_err;
    logic             w_stall;
    logic [3:0]       w_nr;
    logic [SUB_W-1:0] w_sub_last;

    // Stall source: live input when the feature is built in, constant 0 otherwise.
`ifdef AES_SEQ_STALL_EN
    assign w_stall = bus.stall;
`else
    assign w_stall = 1'b0;
`endif

    // Round count from the latched key size (11 is never latched).
    always_comb begin
        case (r_mode)
            2'b00:   w_nr = 4'd10;
            2'b01:   w_nr = 4'd12;
            2'b10:   w_nr = 4'd14;
            default: w_nr = 4'd10;
        endcase
    end

    assign w_sub_last = r_enc_dec ? DEC_LAST : ENC_LAST;

    // Next-state, counter updates and pulse decodes.
    always_comb begin
        w_next_state     = r_state;
        w_round_nxt      = r_round;
        w_sub_nxt        = r_sub;
        w_kgr_nxt        = r_kgr;
        w_mode_nxt       = r_mode;
        w_enc_dec_nxt    = r_enc_dec;
        w_round_start    = 1'b0;
        w_round_complete = 1'b0;
        w_done           = 1'b0;
        w_err            = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.mode == 2'b11) begin
                        w_err = 1'b1;
                    end else begin
                        w_mode_nxt    = bus.mode;
                        w_enc_dec_nxt = bus.enc_dec;
                        w_round_nxt   = 4'd0;
                        w_sub_nxt     = '0;
                        w_kgr_nxt     = 4'd0;
                        w_next_state  = bus.enc_dec ? S_KEYGEN : S_INIT;
                    end
                end
            end
            S_KEYGEN: begin
                if (!w_stall) begin
                    if (r_kgr == w_nr) begin
                        w_kgr_nxt    = 4'd0;
                        w_next_state = S_INIT;
                    end else begin
                        w_kgr_nxt = 4'(r_kgr + 4'd1);
                    end
                end
            end
            S_INIT: begin
                if (!w_stall) begin
                    w_round_start    = 1'b1;
                    w_round_complete = 1'b1;
                    w_round_nxt      = 4'd1;
                    w_sub_nxt        = '0;
                    w_next_state     = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_stall) begin
                    w_round_start = (r_sub == '0);
                    if (r_sub == w_sub_last) begin
                        w_round_complete = 1'b1;
                        w_sub_nxt        = '0;
                        if (r_round == w_nr) begin
                            w_next_state = S_DONE;
                        end else begin
                            w_round_nxt = 4'(r_round + 4'd1);
                        end
                    end else begin
                        w_sub_nxt = SUB_W'(r_sub + SUB_W'(1));
                    end
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_round_nxt  = 4'd0;
                w_sub_nxt    = '0;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State and counter registers; busy/key_gen registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_round   <= 4'd0;
            r_sub     <= '0;
            r_kgr     <= 4'd0;
            r_mode    <= 2'b00;
            r_enc_dec <= 1'b0;
            r_busy    <= 1'b0;
            r_key_gen <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_round   <= w_round_nxt;
            r_sub     <= w_sub_nxt;
            r_kgr     <= w_kgr_nxt;
            r_mode    <= w_mode_nxt;
            r_enc_dec <= w_enc_dec_nxt;
            r_busy    <= (w_next_state != S_IDLE);
            r_key_gen <= (w_next_state == S_KEYGEN);
        end
    end

    assign bus.busy           = r_busy;
    assign bus.enc_dec_reg    = r_enc_dec;
    assign bus.mode_reg       = r_mode;
    assign bus.round          = r_round;
    assign bus.sub_round      = r_sub;
    assign bus.key_gen        = r_key_gen;
    assign bus.key_gen_round  = r_kgr;
    assign bus.round_start    = w_round_start;
    assign bus.round_complete = w_round_complete;
    assign bus.done           = w_done;
    assign bus.err            = w_err;

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

- Parametrised, counter-based round controller for the iterative AES core. It sequences AES-128/192/256 encryption and decryption, including the reverse key-schedule pass for decryption.
- Enc and dec sub-round counts are configurable, and an optional datapath stall is supported.
- It drives the round datapath (round index, sub-round/radix select, round pulses) and the key-expansion unit (key_gen, key_gen_round).

## Interface
- SUB_ROUNDS_ENC, 16, cycles per encryption round 1..Nr (>=1)
- SUB_ROUNDS_DEC, 20, cycles per decryption round 1..Nr (>=1)
- SUB_W, 5, sub-round counter width; both SUB_ROUNDS_* <= 2**SUB_W
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high
- start  in  1  operation request, sampled in IDLE only
- enc_dec  in  1  0=encrypt, 1=decrypt; latched on accepted start
- mode  in  2  00=AES-128 (Nr=10), 01=AES-192 (Nr=12), 10=AES-256 (Nr=14), 11=illegal; latched on accepted start
- stall  in  1  datapath backpressure, freezes sequencing
- busy  out  1  high in every state except IDLE
- enc_dec_reg  out  1  latched enc_dec
- mode_reg  out  2  latched mode
- round  out  4  current round index
- sub_round  out  SUB_W  radix/sub-round select within round
- round_start  out  1  first-cycle pulse of each round
- round_complete  out  1  last-cycle pulse of each round
- key_gen  out  1  high during reverse key-schedule pass
- key_gen_round  out  4  key-schedule index during key_gen
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on rejected start (mode=11)

## Operation
- States: IDLE, KEYGEN, INIT, RUN, DONE.
- All registered outputs reset to 0; state resets to IDLE.
- IDLE:
  - start=1 with mode!=11: latch enc_dec/mode. Go to KEYGEN if decrypt, else INIT.
  - start=1 with mode=11: err=1 for that cycle; stay IDLE; latches unchanged.
- KEYGEN:
  - key_gen=1; key_gen_round counts 0..Nr, one per unstalled cycle.
  - At key_gen_round==Nr (unstalled), go to INIT and clear key_gen_round.
- INIT:
  - Round 0 (initial AddRoundKey), one unstalled cycle.
  - round=0, sub_round=0, round_start=1 and round_complete=1 in the same cycle.
  - Next: RUN with round=1, sub_round=0.
- RUN:
  - S = SUB_ROUNDS_ENC if enc_dec_reg=0, else SUB_ROUNDS_DEC.
  - sub_round increments each unstalled cycle.
  - round_start=1 when sub_round==0; round_complete=1 when sub_round==S-1.
  - At S-1: sub_round wraps to 0. round increments, or goes to DONE if round==Nr.
- DONE: done=1 for one cycle, then IDLE; round and sub_round clear to 0.
- Stall, while stall=1 in KEYGEN/INIT/RUN:
  - state and all counters hold.
  - round_start, round_complete and the key_gen_round advance are suppressed. Each round therefore yields exactly one round_start and one round_complete.
- Stall has no effect in IDLE or DONE.
- start while busy=1 is ignored; no queueing.
- Async reset at any point forces IDLE and zeroes all outputs immediately. There is no partial completion or done pulse.
- Counter arithmetic is unsigned and wraps only at the decoded limits. No counter exceeds its limit.

## Timing
- Cycle 0 is the cycle start is sampled in IDLE.
- Encrypt, no stall: INIT at cycle 1, RUN cycles 2..1+Nr·S_E, done at cycle 2+Nr·S_E. AES-128 with defaults: done at cycle 162.
- Decrypt, no stall: KEYGEN cycles 1..Nr+1, INIT at Nr+2, RUN Nr+3..Nr+2+Nr·S_D, done at Nr+3+Nr·S_D. AES-256 with defaults: done at cycle 297.
- Each stalled cycle adds exactly one cycle of latency.
- busy rises the cycle after an accepted start and falls the cycle after done.
- round_start, round_complete and done are combinational decodes of registered state, gated by stall.
- err is decoded combinationally in IDLE.
- A new start is accepted in the first IDLE cycle after DONE.

## Configuration
- AES_SEQ_STALL_EN:
  - Defined: stall behaves as above.
  - Undefined: the stall port remains but is ignored (internally treated as 0). No stall-hold logic is synthesised, and latency is fixed per the formulas above.

## Test plan
- Encrypt AES-128, defaults, start pulse:
  - round_start at cycles 1,2,18,...,146; round_complete at cycles 1,17,...,161.
  - done at 162; round=10, sub_round=15 at cycle 161.
- Decrypt AES-256, defaults:
  - key_gen high cycles 1..15 with key_gen_round 0..14.
  - INIT at 16; done at 297; 14 round_complete pulses in RUN.
- mode=11 with start:
  - err=1 for that cycle; busy stays 0; mode_reg unchanged.
- AES-192 encrypt, stall=1 for 5 cycles at round 4, sub_round 7, macro defined:
  - counters frozen; no duplicate pulses; done at cycle 194+5=199.
  - Macro undefined: done at cycle 194.
- reset asserted at AES-128 encrypt round 6: all outputs 0 asynchronously; no done; a fresh start completes normally.
- start re-asserted while busy: no effect on round sequence or done timing.
